// File: rtl/train_sched_if.sv
// Host/training-FSM signal bundle for the job scheduler.
// The master side is the host plus the three training state machines. The slave side is the scheduler.
interface train_sched_if #(
  parameter int BATCH_W   = 16,
  parameter int EPOCH_W   = 8,
  parameter int CYC_W     = 24,
  parameter int MODE_LEN  = 2,
  parameter int STATE_LEN = 3
);
  logic                 start;
  logic                 stop;
  logic [MODE_LEN-1:0]  mode_in;
  logic [BATCH_W-1:0]   num_batch;
  logic [EPOCH_W-1:0]   num_epoch;
  logic [STATE_LEN-1:0] main_q;
  logic [STATE_LEN-1:0] fwd_q;
  logic [STATE_LEN-1:0] bwd_q;
  logic                 main_run;
  logic [MODE_LEN-1:0]  main_mode;
  logic                 fwd_run;
  logic                 fwd_set;
  logic                 bwd_run;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [BATCH_W-1:0]   batch_cnt;
  logic [EPOCH_W-1:0]   epoch_cnt;
  logic [CYC_W-1:0]     batch_cycles;

  modport master (
    output start, stop, mode_in, num_batch, num_epoch, main_q, fwd_q, bwd_q,
    input  main_run, main_mode, fwd_run, fwd_set, bwd_run, busy, done, aborted,
           batch_cnt, epoch_cnt, batch_cycles
  );

  modport slave (
    input  start, stop, mode_in, num_batch, num_epoch, main_q, fwd_q, bwd_q,
    output main_run, main_mode, fwd_run, fwd_set, bwd_run, busy, done, aborted,
           batch_cnt, epoch_cnt, batch_cycles
  );
endinterface

// File: rtl/train_sched.sv
// Job-level scheduler for state_main / state_forward / state_backward.
// It runs NUM_EPOCH x NUM_BATCH batches and supports a graceful stop at a batch boundary.
// It also reports job completion and the cycle count of each batch.
module train_sched #(
  parameter int BATCH_W   = 16,
  parameter int EPOCH_W   = 8,
  parameter int CYC_W     = 24,
  parameter int MODE_LEN  = 2,
  parameter int STATE_LEN = 3,
  parameter logic [STATE_LEN-1:0] M_IDLE   = STATE_LEN'(0),
  parameter logic [STATE_LEN-1:0] M_S1     = STATE_LEN'(1),
  parameter logic [STATE_LEN-1:0] M_S2     = STATE_LEN'(2),
  parameter logic [STATE_LEN-1:0] M_S3     = STATE_LEN'(3),
  parameter logic [STATE_LEN-1:0] M_UPDATE = STATE_LEN'(4),
  parameter logic [STATE_LEN-1:0] M_FIN    = STATE_LEN'(5),
  parameter logic [STATE_LEN-1:0] F_IDLE   = STATE_LEN'(0),
  parameter logic [STATE_LEN-1:0] F_FIN    = STATE_LEN'(3),
  parameter logic [STATE_LEN-1:0] B_IDLE   = STATE_LEN'(0),
  parameter logic [STATE_LEN-1:0] B_FIN    = STATE_LEN'(3)
) (
  input logic          clk,
  input logic          rst_n,
  train_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [MODE_LEN-1:0]  mode_q;
  logic [BATCH_W-1:0]   nb_lim, batch_cnt;
  logic [EPOCH_W-1:0]   ep_lim, epoch_cnt;
  logic [CYC_W-1:0]     cyc_cnt, cyc_inc, batch_cycles;
  logic                 fwd_set, done, aborted, busy, stop_pend, first_q;
  logic                 last, nb, boundary, main_run, fwd_run, bwd_run;

  // A restarted job may find state_main still parked in M_FIN from the previous job.
  // That first M_FIN only kicks the FSM and is not counted as a batch boundary.
  assign last     = (batch_cnt == nb_lim - BATCH_W'(1)) && (epoch_cnt == ep_lim - EPOCH_W'(1));
  assign nb       = !(last || stop_pend || bus.stop);
  assign boundary = (state_q == S_RUN) && (bus.main_q == M_FIN) && !first_q;
  assign cyc_inc  = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CYC_W'(1);

  // Run controls: combinational handshake with the training FSMs, only live in S_RUN.
  always_comb begin
    main_run = 1'b0;
    fwd_run  = 1'b0;
    bwd_run  = 1'b0;
    if (state_q == S_RUN) begin
      case (bus.main_q)
        M_IDLE, M_UPDATE: main_run = 1'b1;
        M_S1:             main_run = (bus.fwd_q == F_FIN);
        M_S2:             main_run = (bus.fwd_q == F_FIN) && (bus.bwd_q == B_FIN);
        M_S3:             main_run = (bus.bwd_q == B_FIN);
        M_FIN:            main_run = first_q ? 1'b1 : nb;
        default:          main_run = 1'b0;
      endcase
      if (bus.fwd_q == F_IDLE)     fwd_run = (bus.main_q == M_S1) || (bus.main_q == M_S2);
      else if (bus.fwd_q == F_FIN) fwd_run = main_run;
      else                         fwd_run = 1'b1;
      if (bus.bwd_q == B_IDLE)     bwd_run = (bus.main_q == M_S2) || (bus.main_q == M_S3);
      else if (bus.bwd_q == B_FIN) bwd_run = main_run;
      else                         bwd_run = 1'b1;
    end
  end

  // Next-state logic for the job FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start)
                state_d = (bus.num_batch == '0 || bus.num_epoch == '0) ? S_DONE : S_INIT;
      S_INIT: state_d = S_RUN;
      S_RUN:  if (boundary && !nb) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, job parameters, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      nb_lim       <= '0;
      ep_lim       <= '0;
      batch_cnt    <= '0;
      epoch_cnt    <= '0;
      cyc_cnt      <= '0;
      batch_cycles <= '0;
      fwd_set      <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      busy         <= 1'b0;
      stop_pend    <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      fwd_set <= (state_d == S_INIT);
      done    <= (state_d == S_DONE);
      busy    <= (state_d == S_INIT) || (state_d == S_RUN);
      first_q <= (state_q == S_INIT);
      if (state_q == S_IDLE && bus.start) begin
        mode_q    <= bus.mode_in;
        nb_lim    <= bus.num_batch;
        ep_lim    <= bus.num_epoch;
        batch_cnt <= '0;
        epoch_cnt <= '0;
        aborted   <= 1'b0;
        stop_pend <= 1'b0;
      end
      if ((state_q == S_INIT || state_q == S_RUN) && bus.stop) stop_pend <= 1'b1;
      if (state_q == S_INIT) begin
        cyc_cnt <= '0;
      end else if (state_q == S_RUN) begin
        if (boundary) begin
          batch_cycles <= cyc_inc;
          cyc_cnt      <= '0;
          if (nb) begin
            if (batch_cnt == nb_lim - BATCH_W'(1)) begin
              batch_cnt <= '0;
              epoch_cnt <= epoch_cnt + EPOCH_W'(1);
            end else begin
              batch_cnt <= batch_cnt + BATCH_W'(1);
            end
          end else begin
            aborted <= (stop_pend || bus.stop) && !last;
          end
        end else begin
          cyc_cnt <= cyc_inc;
        end
      end
    end
  end

  assign bus.main_run     = main_run;
  assign bus.main_mode    = mode_q;
  assign bus.fwd_run      = fwd_run;
  assign bus.fwd_set      = fwd_set;
  assign bus.bwd_run      = bwd_run;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.aborted      = aborted;
  assign bus.batch_cnt    = batch_cnt;
  assign bus.epoch_cnt    = epoch_cnt;
  assign bus.batch_cycles = batch_cycles;

endmodule

// File: tb/tb_train_sched.sv
// Directed bench for train_sched.
// Simple behavioural models of state_main, state_forward and state_backward close the loop.
module tb_train_sched;
  localparam logic [2:0] M_IDLE = 3'd0, M_S1 = 3'd1, M_S2 = 3'd2, M_S3 = 3'd3,
                         M_UPDATE = 3'd4, M_FIN = 3'd5;
  localparam logic [2:0] F_IDLE = 3'd0, F_S1 = 3'd1, F_FIN = 3'd3;
  localparam logic [2:0] B_IDLE = 3'd0, B_S1 = 3'd1, B_FIN = 3'd3;
  localparam logic [1:0] TRAIN = 2'd1, EVAL = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  train_sched_if #(.BATCH_W(16), .EPOCH_W(8), .CYC_W(24), .MODE_LEN(2), .STATE_LEN(3)) bus ();

  train_sched #(
    .BATCH_W(16), .EPOCH_W(8), .CYC_W(24), .MODE_LEN(2), .STATE_LEN(3),
    .M_IDLE(M_IDLE), .M_S1(M_S1), .M_S2(M_S2), .M_S3(M_S3), .M_UPDATE(M_UPDATE), .M_FIN(M_FIN),
    .F_IDLE(F_IDLE), .F_FIN(F_FIN), .B_IDLE(B_IDLE), .B_FIN(B_FIN)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Training FSM models: each advances one step per cycle while its run is high.
  logic [2:0] mq, fq, bq;
  assign bus.main_q = mq;
  assign bus.fwd_q  = fq;
  assign bus.bwd_q  = bq;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq <= M_IDLE; fq <= F_IDLE; bq <= B_IDLE;
    end else begin
      if (bus.main_run)
        case (mq)
          M_IDLE:   mq <= M_S1;
          M_S1:     mq <= M_S2;
          M_S2:     mq <= M_S3;
          M_S3:     mq <= M_UPDATE;
          M_UPDATE: mq <= M_FIN;
          default:  mq <= M_IDLE;
        endcase
      if (bus.fwd_set)      fq <= F_IDLE;
      else if (bus.fwd_run) fq <= (fq == F_IDLE) ? F_S1 : (fq == F_S1) ? F_FIN : F_IDLE;
      if (bus.bwd_run)      bq <= (bq == B_IDLE) ? B_S1 : (bq == B_S1) ? B_FIN : B_IDLE;
    end
  end

  // Event monitor: counts pulses and records (epoch,batch) each time main enters M_S1.
  int cyc = 0, fs_cnt, done_cnt, s1_cnt, fin_dist, last_fin;
  bit any_run, fin_run_last;
  logic [2:0]  prev_main = M_IDLE;
  logic [15:0] pairs [8];

  always @(negedge clk) begin
    cyc++;
    if (bus.fwd_set) fs_cnt++;
    if (bus.done) done_cnt++;
    if (bus.fwd_set || bus.main_run || bus.fwd_run || bus.bwd_run) any_run = 1'b1;
    if (mq == M_S1 && prev_main != M_S1) begin
      if (s1_cnt < 8) pairs[s1_cnt] = {bus.epoch_cnt, bus.batch_cnt[7:0]};
      s1_cnt++;
    end
    if (mq == M_FIN && bus.busy) fin_run_last = bus.main_run;
    if (mq == M_FIN && prev_main != M_FIN) begin
      if (last_fin >= 0) fin_dist = cyc - last_fin;
      last_fin = cyc;
    end
    prev_main = mq;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    fs_cnt = 0; done_cnt = 0; s1_cnt = 0; fin_dist = -1; last_fin = -1;
    any_run = 1'b0; fin_run_last = 1'b1;
  endtask

  // Pulse start for one cycle with the given job parameters (called right after a negedge).
  task automatic kick(input logic [1:0] m, input logic [15:0] nbt, input logic [7:0] nep);
    bus.mode_in = m; bus.num_batch = nbt; bus.num_epoch = nep; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    lat = 0;
    while (!bus.done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_timeout"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic wait_cond_b(input int bc, input logic [2:0] ms, input int budget);
    int n = 0;
    while (!(bus.batch_cnt == 16'(bc) && (ms == 3'd7 || mq == ms)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cond_timeout", {31'd0, n < budget}, 32'd1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    bus.mode_in = '0; bus.num_batch = '0; bus.num_epoch = '0;
    clr_mon();
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_fwd_set", {31'd0, bus.fwd_set}, 0);
    chk("rst_batch", {16'd0, bus.batch_cnt}, 0);
    chk("rst_cycles", {8'd0, bus.batch_cycles}, 0);
    chk("rst_main_run", {31'd0, bus.main_run}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job: 3 batches, 1 epoch. Each batch takes 12 cycles through the models.
    clr_mon();
    kick(TRAIN, 16'd3, 8'd1);
    chk("basic_busy_init", {31'd0, bus.busy}, 1);
    chk("basic_fwd_set_init", {31'd0, bus.fwd_set}, 1);
    wait_done("basic", 200, lat);
    chk("basic_aborted", {31'd0, bus.aborted}, 0);
    chk("basic_batch_end", {16'd0, bus.batch_cnt}, 2);
    chk("basic_busy_done", {31'd0, bus.busy}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("basic_fwd_set_cnt", fs_cnt, 1);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_s1_cnt", s1_cnt, 3);
    chk("basic_batch_seq0", {16'd0, pairs[0]}, 32'h0000);
    chk("basic_batch_seq1", {16'd0, pairs[1]}, 32'h0001);
    chk("basic_batch_seq2", {16'd0, pairs[2]}, 32'h0002);
    chk("basic_last_fin_run", {31'd0, fin_run_last}, 0);
    chk("basic_mode", {30'd0, bus.main_mode}, TRAIN);
    chk("basic_cycles", {8'd0, bus.batch_cycles}, 12);
    chk("basic_cycles_meas", {8'd0, bus.batch_cycles}, fin_dist);

    // Restart while main is parked in M_FIN: exactly one batch.
    clr_mon();
    kick(EVAL, 16'd1, 8'd1);
    wait_done("restart", 200, lat);
    chk("restart_aborted", {31'd0, bus.aborted}, 0);
    chk("restart_batch", {16'd0, bus.batch_cnt}, 0);
    chk("restart_mode", {30'd0, bus.main_mode}, EVAL);
    repeat (2) @(negedge clk);
    #1;
    chk("restart_s1_cnt", s1_cnt, 1);

    // Epoch wrap: 2 batches x 2 epochs.
    clr_mon();
    kick(TRAIN, 16'd2, 8'd2);
    wait_done("epoch", 300, lat);
    chk("epoch_end_e", {24'd0, bus.epoch_cnt}, 1);
    chk("epoch_end_b", {16'd0, bus.batch_cnt}, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("epoch_s1_cnt", s1_cnt, 4);
    chk("epoch_seq0", {16'd0, pairs[0]}, 32'h0000);
    chk("epoch_seq1", {16'd0, pairs[1]}, 32'h0001);
    chk("epoch_seq2", {16'd0, pairs[2]}, 32'h0100);
    chk("epoch_seq3", {16'd0, pairs[3]}, 32'h0101);

    // Stop during batch 1 (main in M_S2): batch 1 completes, then the job aborts.
    clr_mon();
    kick(TRAIN, 16'd5, 8'd1);
    wait_cond_b(1, M_S2, 200);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    wait_done("stop", 200, lat);
    chk("stop_aborted", {31'd0, bus.aborted}, 1);
    chk("stop_batch", {16'd0, bus.batch_cnt}, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("stop_s1_cnt", s1_cnt, 2);
    chk("stop_done_cnt", done_cnt, 1);
    chk("stop_aborted_hold", {31'd0, bus.aborted}, 1);

    // Zero batch limit: straight to done, no run controls at all.
    clr_mon();
    kick(TRAIN, 16'd0, 8'd1);
    wait_done("zero", 10, lat);
    chk("zero_lat", lat, 0);
    chk("zero_aborted", {31'd0, bus.aborted}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_no_run", {31'd0, any_run}, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy", {31'd0, bus.busy}, 0);

    // Reset in the middle of a job at batch 2.
    clr_mon();
    kick(EVAL, 16'd5, 8'd1);
    wait_cond_b(2, 3'd7, 300);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", {31'd0, bus.busy}, 0);
    chk("mid_done", {31'd0, bus.done}, 0);
    chk("mid_aborted", {31'd0, bus.aborted}, 0);
    chk("mid_batch", {16'd0, bus.batch_cnt}, 0);
    chk("mid_epoch", {24'd0, bus.epoch_cnt}, 0);
    chk("mid_cycles", {8'd0, bus.batch_cycles}, 0);
    chk("mid_mode", {30'd0, bus.main_mode}, 0);
    chk("mid_fwd_set", {31'd0, bus.fwd_set}, 0);
    chk("mid_runs", {29'd0, bus.main_run, bus.fwd_run, bus.bwd_run}, 0);
    @(negedge clk);
    chk("mid_runs_next", {29'd0, bus.main_run, bus.fwd_run, bus.bwd_run}, 0);
    chk("mid_busy_next", {31'd0, bus.busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
